// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between EX and MEM writeback.
// Optional RAW scoreboard is compiled in when REGFILE_WB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_rd,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    output logic              issue_hazard
);

    // Handshake: a writeback transfers at a rising edge when valid && ready.
    // The requester holds valid/rd/data stable until ready; ready depends only on
    // the valids and rr_last, is never raised without its valid, and at most one is high.
    localparam logic SRC_EX  = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    logic              rr_last_q, rr_last_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic              grant_any;
    logic [ADDR_W-1:0] grant_rd;
    logic [DATA_W-1:0] grant_data;

    // On a tie, EX wins unless it was the last source granted.
    always_comb begin
        ex_ready  = 1'b0;
        mem_ready = 1'b0;
        if (rst_n) begin
            if (ex_valid && (!mem_valid || rr_last_q == SRC_MEM)) begin
                ex_ready = 1'b1;
            end else if (mem_valid) begin
                mem_ready = 1'b1;
            end
        end
    end

    always_comb begin
        grant_any  = ex_ready | mem_ready;
        grant_rd   = mem_ready ? mem_rd : ex_rd;
        grant_data = mem_ready ? mem_data : ex_data;
    end

    always_comb begin
        rr_last_d  = rr_last_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (ex_ready) begin
            rr_last_d = SRC_EX;
        end else if (mem_ready) begin
            rr_last_d = SRC_MEM;
        end
        // x0 writes are accepted but never reach the register file.
        if (grant_any) begin
            rf_we_d    = (grant_rd != '0);
            rf_rd_d    = grant_rd;
            rf_wdata_d = grant_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q  <= SRC_MEM;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            rr_last_q  <= rr_last_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q, busy_d;

    // Clear first, then set, so a newer producer issued on the same edge keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (grant_any && grant_rd != '0) begin
            busy_d[grant_rd] = 1'b0;
        end
        if (sb_set && sb_rd != '0) begin
            busy_d[sb_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign issue_hazard = busy_q[issue_rs1] | busy_q[issue_rs2];
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{sb_set, sb_rd, issue_rs1, issue_rs2};
    assign issue_hazard     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, contention, round-robin, x0, same-rd
// serialization and scoreboard hazard behaviour (or hazard tied low without the macro).
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              ex_valid;
    logic              ex_ready;
    logic [ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0] ex_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wdata;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_rd;
    logic [ADDR_W-1:0] issue_rs1;
    logic [ADDR_W-1:0] issue_rs2;
    logic              issue_hazard;

    int n_vec;
    int n_err;

    logic [DATA_W-1:0] rf_model [2**ADDR_W];

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_rd        (ex_rd),
        .ex_data      (ex_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .sb_set       (sb_set),
        .sb_rd        (sb_rd),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_hazard (issue_hazard)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file that consumes the write port.
    always @(posedge clk) begin
        if (rf_we) rf_model[rf_rd] <= rf_wdata;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests, check readies mid-cycle, then step past the edge.
    task automatic wb_cycle(input string tag,
                            input logic ev, input logic [ADDR_W-1:0] erd, input logic [DATA_W-1:0] ed,
                            input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md,
                            input logic exp_er, input logic exp_mr);
        ex_valid  = ev;
        ex_rd     = erd;
        ex_data   = ed;
        mem_valid = mv;
        mem_rd    = mrd;
        mem_data  = md;
        #1;
        check_val({tag, " ex_ready"}, 32'(ex_ready), 32'(exp_er));
        check_val({tag, " mem_ready"}, 32'(mem_ready), 32'(exp_mr));
        @(posedge clk);
        #1;
        ex_valid  = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [ADDR_W-1:0] rd,
                            input logic [DATA_W-1:0] wd);
        check_val({tag, " rf_we"}, 32'(rf_we), 32'(we));
        check_val({tag, " rf_rd"}, 32'(rf_rd), 32'(rd));
        check_val({tag, " rf_wdata"}, rf_wdata, wd);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        ex_valid  = 1'b0;
        ex_rd     = '0;
        ex_data   = '0;
        mem_valid = 1'b0;
        mem_rd    = '0;
        mem_data  = '0;
        sb_set    = 1'b0;
        sb_rd     = '0;
        issue_rs1 = '0;
        issue_rs2 = '0;
        for (int i = 0; i < 2**ADDR_W; i++) rf_model[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check_rf("reset_init", 1'b0, 5'd0, 32'd0);
        check_val("reset_ex_ready", 32'(ex_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1. Reset mid-grant clears the write port immediately.
        wb_cycle("pre_reset", 1'b1, 5'd1, 32'd11, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        check_rf("pre_reset", 1'b1, 5'd1, 32'd11);
        ex_valid = 1'b1;
        ex_rd    = 5'd1;
        ex_data  = 32'd11;
        #1;
        rst_n = 1'b0;
        #1;
        check_rf("async_reset", 1'b0, 5'd0, 32'd0);
        check_val("reset_ex_ready_held", 32'(ex_ready), 32'd0);
        ex_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wb_cycle("post_reset", 1'b1, 5'd3, 32'd100, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        check_rf("post_reset", 1'b1, 5'd3, 32'd100);

        // 4. x0 from MEM is accepted but not written (also hands rr_last to MEM).
        wb_cycle("x0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd55, 1'b0, 1'b1);
        check_val("x0 rf_we", 32'(rf_we), 32'd0);

        // 2. Contention: EX first, MEM next, then idle holds rd/data.
        wb_cycle("cont0", 1'b1, 5'd2, 32'd100, 1'b1, 5'd4, 32'd200, 1'b1, 1'b0);
        check_rf("cont0", 1'b1, 5'd2, 32'd100);
        wb_cycle("cont1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd200, 1'b0, 1'b1);
        check_rf("cont1", 1'b1, 5'd4, 32'd200);
        wb_cycle("idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_rf("idle_hold", 1'b0, 5'd4, 32'd200);

        // 3. Both always valid: strict alternation EX, MEM, EX, MEM.
        for (int i = 0; i < 4; i++) begin
            wb_cycle($sformatf("rr%0d", i),
                     1'b1, 5'(8 + i), 32'(1000 + i), 1'b1, 5'(16 + i), 32'(2000 + i),
                     (i % 2) == 0, (i % 2) == 1);
            if ((i % 2) == 0) check_rf($sformatf("rr%0d", i), 1'b1, 5'(8 + i), 32'(1000 + i));
            else              check_rf($sformatf("rr%0d", i), 1'b1, 5'(16 + i), 32'(2000 + i));
        end

        // 5. Same rd from both: MEM's value is final.
        wb_cycle("same_rd0", 1'b1, 5'd5, 32'd7, 1'b1, 5'd5, 32'd9, 1'b1, 1'b0);
        check_rf("same_rd0", 1'b1, 5'd5, 32'd7);
        wb_cycle("same_rd1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'd9, 1'b0, 1'b1);
        wb_cycle("same_rd_idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_val("same_rd reg5", rf_model[5], 32'd9);
        check_val("reg3", rf_model[3], 32'd100);
        check_val("reg4", rf_model[4], 32'd200);

        // 6. Scoreboard.
        issue_rs1 = 5'd6;
        issue_rs2 = 5'd0;
        sb_set    = 1'b1;
        sb_rd     = 5'd6;
        @(posedge clk);
        #1;
        sb_set = 1'b0;
`ifdef REGFILE_WB_SCOREBOARD_EN
        check_val("sb_set hazard", 32'(issue_hazard), 32'd1);
        issue_rs1 = 5'd0;
        issue_rs2 = 5'd6;
        #1;
        check_val("sb_rs2 hazard", 32'(issue_hazard), 32'd1);
        issue_rs2 = 5'd7;
        #1;
        check_val("sb_other hazard", 32'(issue_hazard), 32'd0);
        issue_rs1 = 5'd6;
        wb_cycle("sb_clear", 1'b1, 5'd6, 32'd66, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        check_val("sb_clear hazard", 32'(issue_hazard), 32'd0);
        sb_set = 1'b1;
        sb_rd  = 5'd6;
        @(posedge clk);
        #1;
        sb_set = 1'b0;
        check_val("sb_reset hazard", 32'(issue_hazard), 32'd1);
        sb_set = 1'b1;
        wb_cycle("sb_both", 1'b1, 5'd6, 32'd67, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        sb_set = 1'b0;
        check_val("sb_set_wins hazard", 32'(issue_hazard), 32'd1);
        sb_set = 1'b1;
        sb_rd  = 5'd0;
        issue_rs1 = 5'd0;
        issue_rs2 = 5'd0;
        @(posedge clk);
        #1;
        sb_set = 1'b0;
        check_val("sb_x0 hazard", 32'(issue_hazard), 32'd0);
`else
        check_val("no_sb hazard", 32'(issue_hazard), 32'd0);
        wb_cycle("no_sb_wb", 1'b1, 5'd6, 32'd66, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        check_val("no_sb hazard2", 32'(issue_hazard), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
